// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiplier
// and restoring divider, with a one-cycle fast path for divide-by-zero and signed overflow.
module mdu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIVU   = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic             is_div_c;
  logic             a_signed_c, b_signed_c;
  logic             a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic             div_zero_c, div_ovf_c, fast_c;
  logic [WIDTH-1:0] fast_res_c;

  logic [WIDTH:0]   mul_sum_c;
  logic [ACC_W-1:0] mul_step_c;
  logic [WIDTH:0]   rem_sh_c;
  logic             sub_ok_c;
  logic [WIDTH-1:0] sub_diff_c;
  logic [ACC_W-1:0] div_step_c;

  logic [ACC_W-1:0] prod_c;
  logic [WIDTH-1:0] quot_c, rem_c;
  logic [WIDTH-1:0] fix_res_c;

  // Operand decode at accept: signedness, magnitudes and fast-path detection.
  // MUL is treated as signed x signed; its low word is identical either way.
  always_comb begin
    is_div_c   = funct3[2];
    a_signed_c = is_div_c ? ~funct3[0] : (funct3 != F3_MULHU);
    b_signed_c = is_div_c ? ~funct3[0] : ~funct3[1];
    a_neg_c    = a_signed_c & op_a[WIDTH-1];
    b_neg_c    = b_signed_c & op_b[WIDTH-1];
    a_mag_c    = a_neg_c ? (~op_a + WIDTH'(1)) : op_a;
    b_mag_c    = b_neg_c ? (~op_b + WIDTH'(1)) : op_b;
    div_zero_c = (op_b == '0);
    div_ovf_c  = ~funct3[0] & (op_a == INT_MIN) & (op_b == '1);
    fast_c     = is_div_c & (div_zero_c | div_ovf_c);
    if (div_zero_c) begin
      fast_res_c = funct3[1] ? op_a : '1;
    end else begin
      fast_res_c = funct3[1] ? '0 : INT_MIN;
    end
  end

  // One iteration of each datapath; acc holds {product} or {rem, quot}.
  always_comb begin
    mul_sum_c  = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, opnd_q};
    mul_step_c = acc_q[0] ? {mul_sum_c, acc_q[WIDTH-1:1]}
                          : {1'b0, acc_q[ACC_W-1:1]};
    rem_sh_c   = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
    sub_ok_c   = (rem_sh_c >= {1'b0, opnd_q});
    sub_diff_c = rem_sh_c[WIDTH-1:0] - opnd_q;
    div_step_c = sub_ok_c ? {sub_diff_c, acc_q[WIDTH-2:0], 1'b1}
                          : {rem_sh_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end

  // Sign fix-up and result selection in FIX.
  always_comb begin
    prod_c = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;
    quot_c = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_c  = rneg_q ? (~acc_q[ACC_W-1:WIDTH] + WIDTH'(1)) : acc_q[ACC_W-1:WIDTH];
    case (f3_q)
      F3_MUL:                fix_res_c = prod_c[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res_c = prod_c[ACC_W-1:WIDTH];
      3'b100, F3_DIVU:       fix_res_c = quot_c;
      default:               fix_res_c = rem_c;
    endcase
  end

  // Next-state and register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (fast_c) begin
            result_d = fast_res_c;
            done_d   = 1'b1;
          end else begin
            f3_d    = funct3;
            neg_d   = a_neg_c ^ b_neg_c;
            rneg_d  = a_neg_c;
            cnt_d   = '0;
            state_d = S_CALC;
            if (is_div_c) begin
              acc_d  = {WIDTH'(0), a_mag_c};
              opnd_d = b_mag_c;
            end else begin
              acc_d  = {WIDTH'(0), b_mag_c};
              opnd_d = a_mag_c;
            end
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = f3_q[2] ? div_step_c : mul_step_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          result_d = fix_res_c;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign stall  = busy | (start & ~fast_c);
  assign done   = done_q;
  assign result = result_q;

endmodule
